// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, counter widths and parameter limits for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } pipe_state_e;

    localparam int MEM_TIMEOUT_MIN = 2;
    localparam int MEM_TIMEOUT_MAX = 255;
    localparam int FLUSH_SLOTS_MIN = 1;
    localparam int FLUSH_SLOTS_MAX = 4;

    localparam int WAIT_CNT_W = 8;
    localparam int SLOT_CNT_W = 3;

    function automatic int clampRange(input int value, input int lo, input int hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Enable-gated free-running performance counter; wraps silently at 2^W.
module pipe_ctrl_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: turns hazard, mispredict and memory-wait requests into stage enables.
// Define PIPE_CTRL_PERF_EN to build the stall/flush/memory-wait performance counters; otherwise they read 0.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNT_W       = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall_load,
    input  logic               i_flush_branch,
    input  logic               i_mem_req,
    input  logic               i_mem_ack,
    output logic               o_pc_en,
    output logic               o_if_id_en,
    output logic               o_if_id_flush,
    output logic               o_id_ex_en,
    output logic               o_id_ex_flush,
    output logic               o_ex_mem_en,
    output logic               o_mem_wb_bubble,
    output logic [STATE_W-1:0] o_state,
    output logic               o_mem_timeout,
    output logic [CNT_W-1:0]   o_stall_cycles,
    output logic [CNT_W-1:0]   o_flush_events,
    output logic [CNT_W-1:0]   o_memwait_cycles
);

    localparam int TimeoutEff = clampRange(MEM_TIMEOUT, MEM_TIMEOUT_MIN, MEM_TIMEOUT_MAX);
    localparam int SlotsEff   = clampRange(FLUSH_SLOTS, FLUSH_SLOTS_MIN, FLUSH_SLOTS_MAX);
    localparam logic [WAIT_CNT_W-1:0] WaitLast = WAIT_CNT_W'(TimeoutEff - 1);
    localparam logic [SLOT_CNT_W-1:0] SlotInit = SLOT_CNT_W'(SlotsEff - 1);

    pipe_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic [SLOT_CNT_W-1:0]   slotCnt_q, slotCnt_d;
    logic                    memTimeout_q, memTimeout_d;

    logic memWait;
    logic freeze;
    logic takeFlush;
    logic takeStall;
    logic shadowFlush;

    assign memWait = i_mem_req & ~i_mem_ack;

    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        slotCnt_d    = slotCnt_q;
        memTimeout_d = memTimeout_q;
        freeze       = 1'b0;
        takeFlush    = 1'b0;
        takeStall    = 1'b0;
        shadowFlush  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (memWait) begin
                    freeze    = 1'b1;
                    state_d   = ST_MEM_WAIT;
                    waitCnt_d = '0;
                end else if (i_flush_branch) begin
                    takeFlush = 1'b1;
                    if (SlotsEff > 1) begin
                        state_d   = ST_FLUSH;
                        slotCnt_d = SlotInit;
                    end
                end else if (i_stall_load) begin
                    takeStall = 1'b1;
                end
            end
            // An abandoned access releases the pipeline exactly as an ack would.
            ST_MEM_WAIT: begin
                if (i_mem_ack) begin
                    state_d = ST_RUN;
                end else if (waitCnt_q == WaitLast) begin
                    memTimeout_d = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    freeze    = 1'b1;
                    waitCnt_d = waitCnt_q + WAIT_CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (memWait) begin
                    freeze = 1'b1;
                end else begin
                    shadowFlush = 1'b1;
                    slotCnt_d   = slotCnt_q - SLOT_CNT_W'(1);
                    if (slotCnt_q == SLOT_CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_RUN;
            waitCnt_q    <= '0;
            slotCnt_q    <= '0;
            memTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            slotCnt_q    <= slotCnt_d;
            memTimeout_q <= memTimeout_d;
        end
    end

    // Every strobe is gated by reset so the datapath sees a fully quiet controller while held.
    assign o_pc_en         = i_rst_n & ~freeze & ~takeStall;
    assign o_if_id_en      = i_rst_n & ~freeze & ~takeStall;
    assign o_if_id_flush   = i_rst_n & (takeFlush | shadowFlush);
    assign o_id_ex_en      = i_rst_n & ~freeze;
    assign o_id_ex_flush   = i_rst_n & (takeFlush | takeStall);
    assign o_ex_mem_en     = i_rst_n & ~freeze;
    assign o_mem_wb_bubble = i_rst_n & freeze;
    assign o_state         = state_q;
    assign o_mem_timeout   = memTimeout_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (takeStall),
        .o_count (o_stall_cycles)
    );

    pipe_ctrl_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (takeFlush),
        .o_count (o_flush_events)
    );

    pipe_ctrl_perf_cnt #(.W(CNT_W)) u_memwait_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (freeze),
        .o_count (o_memwait_cycles)
    );
`else
    assign o_stall_cycles   = '0;
    assign o_flush_events   = '0;
    assign o_memwait_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, reset-abort sequences, then random traffic against a reference model.
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int FLUSH_SLOTS = 3;
    localparam int CNT_W       = 8;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}
    localparam logic [6:0] OUT_RESET  = 7'b0000000;
    localparam logic [6:0] OUT_NORMAL = 7'b1101010;
    localparam logic [6:0] OUT_FREEZE = 7'b0000001;
    localparam logic [6:0] OUT_STALL  = 7'b0001110;
    localparam logic [6:0] OUT_FLUSH  = 7'b1111110;
    localparam logic [6:0] OUT_SHADOW = 7'b1111010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstN;
    logic             stallLoad, flushBranch, memReq, memAck;
    logic             pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbBubble;
    logic [1:0]       state;
    logic             memTimeout;
    logic [CNT_W-1:0] stallCycles, flushEvents, memwaitCycles;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: tracks how long the current memory wait has lasted and how many
    // flush-shadow cycles remain, plus the observable counters.
    bit mWaiting;
    int mWaitAge;
    int mShadow;
    bit mTimedOut;
    int mStalls, mFlushes, mFreezes;

    logic [6:0]       expOut;
    logic [1:0]       expState;
    logic             expTmo;
    logic [CNT_W-1:0] expStalls, expFlushes, expFreezes;

    typedef struct {
        bit         st;
        bit         fl;
        bit         rq;
        bit         ak;
        logic [6:0] out;
        logic [1:0] state;
    } vec_t;

    vec_t vecs[$];

    pipeline_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .FLUSH_SLOTS (FLUSH_SLOTS),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rstN),
        .i_stall_load     (stallLoad),
        .i_flush_branch   (flushBranch),
        .i_mem_req        (memReq),
        .i_mem_ack        (memAck),
        .o_pc_en          (pcEn),
        .o_if_id_en       (ifIdEn),
        .o_if_id_flush    (ifIdFlush),
        .o_id_ex_en       (idExEn),
        .o_id_ex_flush    (idExFlush),
        .o_ex_mem_en      (exMemEn),
        .o_mem_wb_bubble  (memWbBubble),
        .o_state          (state),
        .o_mem_timeout    (memTimeout),
        .o_stall_cycles   (stallCycles),
        .o_flush_events   (flushEvents),
        .o_memwait_cycles (memwaitCycles)
    );

    function automatic logic [CNT_W-1:0] perfExpect(input int n);
        return PerfOn ? CNT_W'(n) : '0;
    endfunction

    task automatic modelReset();
        mWaiting  = 1'b0;
        mWaitAge  = 0;
        mShadow   = 0;
        mTimedOut = 1'b0;
        mStalls   = 0;
        mFlushes  = 0;
        mFreezes  = 0;
    endtask

    task automatic captureRegs();
        expTmo     = mTimedOut;
        expStalls  = perfExpect(mStalls);
        expFlushes = perfExpect(mFlushes);
        expFreezes = perfExpect(mFreezes);
    endtask

    task automatic modelStep(input bit st, input bit fl, input bit rq, input bit ak);
        bit memStall;
        memStall = rq && !ak;
        expState = mWaiting ? 2'd1 : ((mShadow > 0) ? 2'd2 : 2'd0);
        if (mWaiting) begin
            if (ak) begin
                expOut   = OUT_NORMAL;
                mWaiting = 1'b0;
            end else if (mWaitAge == MEM_TIMEOUT) begin
                expOut    = OUT_NORMAL;
                mWaiting  = 1'b0;
                mTimedOut = 1'b1;
            end else begin
                expOut = OUT_FREEZE;
                mWaitAge++;
                mFreezes++;
            end
        end else if (mShadow > 0) begin
            if (memStall) begin
                expOut = OUT_FREEZE;
                mFreezes++;
            end else begin
                expOut = OUT_SHADOW;
                mShadow--;
            end
        end else if (memStall) begin
            expOut   = OUT_FREEZE;
            mWaiting = 1'b1;
            mWaitAge = 1;
            mFreezes++;
        end else if (fl) begin
            expOut  = OUT_FLUSH;
            mShadow = FLUSH_SLOTS - 1;
            mFlushes++;
        end else if (st) begin
            expOut = OUT_STALL;
            mStalls++;
        end else begin
            expOut = OUT_NORMAL;
        end
    endtask

    task automatic applyStimulus(input bit st, input bit fl, input bit rq, input bit ak);
        @(negedge clk);
        stallLoad   = st;
        flushBranch = fl;
        memReq      = rq;
        memAck      = ak;
        #1;
        captureRegs();
        modelStep(st, fl, rq, ak);
    endtask

    task automatic checkOutput(input string name, input logic [6:0] wantOut, input logic [1:0] wantState);
        logic [6:0] gotOut;
        gotOut = {pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbBubble};
        compareCount++;
        if (gotOut !== wantOut) begin
            mismatchCount++;
            $display("[TB] FAIL %s outputs: got %b want %b", name, gotOut, wantOut);
        end
        compareCount++;
        if (state !== wantState) begin
            mismatchCount++;
            $display("[TB] FAIL %s state: got %0d want %0d", name, state, wantState);
        end
        compareCount++;
        if (memTimeout !== expTmo) begin
            mismatchCount++;
            $display("[TB] FAIL %s mem_timeout: got %b want %b", name, memTimeout, expTmo);
        end
        compareCount++;
        if ({stallCycles, flushEvents, memwaitCycles} !== {expStalls, expFlushes, expFreezes}) begin
            mismatchCount++;
            $display("[TB] FAIL %s counters: got %0d/%0d/%0d want %0d/%0d/%0d", name,
                     stallCycles, flushEvents, memwaitCycles, expStalls, expFlushes, expFreezes);
        end
    endtask

    task automatic addVec(input bit st, input bit fl, input bit rq, input bit ak,
                          input logic [6:0] out, input logic [1:0] st2);
        vec_t v;
        v.st    = st;
        v.fl    = fl;
        v.rq    = rq;
        v.ak    = ak;
        v.out   = out;
        v.state = st2;
        vecs.push_back(v);
    endtask

    initial begin
        // st fl rq ak : expected outputs, expected state
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);
        addVec(1, 0, 0, 0, OUT_STALL,  2'd0);
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd0);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd1);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd1);
        addVec(0, 0, 1, 1, OUT_NORMAL, 2'd1);
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);
        addVec(0, 1, 0, 0, OUT_FLUSH,  2'd0);
        addVec(0, 0, 0, 0, OUT_SHADOW, 2'd2);
        addVec(0, 0, 0, 0, OUT_SHADOW, 2'd2);
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);
        addVec(1, 1, 0, 0, OUT_FLUSH,  2'd0);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd2);
        addVec(0, 0, 0, 0, OUT_SHADOW, 2'd2);
        addVec(0, 0, 0, 0, OUT_SHADOW, 2'd2);
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);
        addVec(0, 1, 1, 0, OUT_FREEZE, 2'd0);
        addVec(0, 1, 1, 0, OUT_FREEZE, 2'd1);
        addVec(0, 1, 1, 1, OUT_NORMAL, 2'd1);
        addVec(0, 1, 0, 0, OUT_FLUSH,  2'd0);
        addVec(0, 0, 0, 0, OUT_SHADOW, 2'd2);
        addVec(0, 0, 0, 0, OUT_SHADOW, 2'd2);
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd0);
        addVec(1, 0, 1, 0, OUT_FREEZE, 2'd1);
        addVec(1, 0, 1, 1, OUT_NORMAL, 2'd1);
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd0);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd1);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd1);
        addVec(0, 0, 1, 0, OUT_FREEZE, 2'd1);
        addVec(0, 0, 1, 0, OUT_NORMAL, 2'd1);
        addVec(0, 0, 0, 0, OUT_NORMAL, 2'd0);

        rstN        = 1'b0;
        stallLoad   = 1'b0;
        flushBranch = 1'b0;
        memReq      = 1'b0;
        memAck      = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        captureRegs();
        checkOutput("reset_idle", OUT_RESET, 2'd0);
        stallLoad = 1'b1;
        memReq    = 1'b1;
        #1;
        checkOutput("reset_inputs_active", OUT_RESET, 2'd0);
        @(negedge clk);
        stallLoad = 1'b0;
        memReq    = 1'b0;
        rstN      = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].st, vecs[i].fl, vecs[i].rq, vecs[i].ak);
            checkOutput($sformatf("vec%0d", i), vecs[i].out, vecs[i].state);
        end

        compareCount++;
        if (memTimeout !== 1'b1) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_sticky: got %b want 1", memTimeout);
        end

        // Reset asserted in the middle of a memory wait must abort straight to a quiet RUN.
        applyStimulus(0, 0, 1, 0);
        checkOutput("rstwait_enter", OUT_FREEZE, 2'd0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("rstwait_hold", OUT_FREEZE, 2'd1);
        #2 rstN = 1'b0;
        #1;
        modelReset();
        captureRegs();
        checkOutput("rstwait_abort", OUT_RESET, 2'd0);
        @(negedge clk);
        memReq = 1'b0;
        rstN   = 1'b1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("first_after_reset", OUT_STALL, 2'd0);

        applyStimulus(0, 1, 0, 0);
        checkOutput("rstflush_req", OUT_FLUSH, 2'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rstflush_shadow", OUT_SHADOW, 2'd2);
        #2 rstN = 1'b0;
        #1;
        modelReset();
        captureRegs();
        checkOutput("rstflush_abort", OUT_RESET, 2'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("after_flush_abort", OUT_NORMAL, 2'd0);

        for (int n = 0; n < 3000; n++) begin
            bit st, fl, rq, ak;
            st = ($urandom_range(0, 99) < 25);
            fl = ($urandom_range(0, 99) < 15);
            rq = ($urandom_range(0, 99) < 30);
            ak = ($urandom_range(0, 99) < 45);
            applyStimulus(st, fl, rq, ak);
            checkOutput($sformatf("rand%0d", n), expOut, expState);
        end

        applyStimulus(0, 0, 0, 0);
        checkOutput("final", expOut, expState);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
